// File: rtl/fixed_point_accumulator.sv
// Saturating accumulator for signed fixed-point products from the Booth multiplier.
// Sums a programmed number of terms, counting one per rising edge of mul_finish.
module fixed_point_accumulator #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8,
  parameter int GUARD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] term_count,
  input  logic [WIDTH-1:0]   mul_result,
  input  logic               mul_overflow,
  input  logic               mul_finish,
  output logic [WIDTH-1:0]   acc_result,
  output logic               acc_overflow,
  output logic               done,
  output logic               busy
);

  localparam int SW = WIDTH + GUARD;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]               state_r;
  logic [1:0]               state_s;
  logic signed [SW-1:0]     sum_r;
  logic signed [SW-1:0]     sum_s;
  logic signed [SW-1:0]     product_s;
  logic [COUNT_W-1:0]       count_r;
  logic [COUNT_W-1:0]       count_s;
  logic [COUNT_W-1:0]       count_inc_s;
  logic [COUNT_W-1:0]       target_r;
  logic [COUNT_W-1:0]       target_s;
  logic                     sticky_r;
  logic                     sticky_s;
  logic                     fin_q_r;
  logic                     accept_s;
  logic                     enter_done_s;
  logic [WIDTH-1:0]         acc_result_r;
  logic                     acc_overflow_r;
  logic                     done_r;
  logic                     busy_r;

  // A sum fits in WIDTH bits when every guard bit matches the WIDTH-1 sign bit.
  function automatic logic fits_width(input logic signed [SW-1:0] v);
    return (v[SW-1:WIDTH-1] == {(GUARD+1){v[WIDTH-1]}});
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic signed [SW-1:0] v);
    logic [WIDTH-1:0] r;
    if (fits_width(v)) begin
      r = v[WIDTH-1:0];
    end else if (v[SW-1]) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  assign accept_s    = mul_finish & ~fin_q_r;
  assign product_s   = {{GUARD{mul_result[WIDTH-1]}}, mul_result};
  assign count_inc_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};

  // Next-state and datapath; clear overrides everything, including a coincident product.
  always_comb begin
    state_s      = state_r;
    sum_s        = sum_r;
    count_s      = count_r;
    target_s     = target_r;
    sticky_s     = sticky_r;
    enter_done_s = 1'b0;
    if (clear) begin
      target_s = term_count;
      sum_s    = {SW{1'b0}};
      count_s  = {COUNT_W{1'b0}};
      sticky_s = 1'b0;
      if (term_count == {COUNT_W{1'b0}}) begin
        state_s      = ST_DONE;
        enter_done_s = 1'b1;
      end else begin
        state_s = ST_ACCUM;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_ACCUM: begin
          if (accept_s) begin
            sum_s    = sum_r + product_s;
            sticky_s = sticky_r | mul_overflow;
            count_s  = count_inc_s;
            if (count_inc_s == target_r) begin
              state_s      = ST_DONE;
              enter_done_s = 1'b1;
            end else begin
              state_s = ST_ACCUM;
            end
          end else begin
            state_s = ST_ACCUM;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s  = ST_IDLE;
          sum_s    = {SW{1'b0}};
          count_s  = {COUNT_W{1'b0}};
          target_s = {COUNT_W{1'b0}};
          sticky_s = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; results latch only on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      sum_r          <= {SW{1'b0}};
      count_r        <= {COUNT_W{1'b0}};
      target_r       <= {COUNT_W{1'b0}};
      sticky_r       <= 1'b0;
      fin_q_r        <= 1'b0;
      acc_result_r   <= {WIDTH{1'b0}};
      acc_overflow_r <= 1'b0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r  <= state_s;
      sum_r    <= sum_s;
      count_r  <= count_s;
      target_r <= target_s;
      sticky_r <= sticky_s;
      fin_q_r  <= mul_finish;
      done_r   <= (state_s == ST_DONE);
      busy_r   <= (state_s == ST_ACCUM);
      if (enter_done_s) begin
        acc_result_r   <= saturate(sum_s);
        acc_overflow_r <= sticky_s | ~fits_width(sum_s);
      end
    end
  end

  assign acc_result   = acc_result_r;
  assign acc_overflow = acc_overflow_r;
  assign done         = done_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed testbench for fixed_point_accumulator with hand-computed expected sums.
module tb_fixed_point_accumulator;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [7:0]  term_count;
  logic [15:0] mul_result;
  logic        mul_overflow;
  logic        mul_finish;
  logic [15:0] acc_result;
  logic        acc_overflow;
  logic        done;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  fixed_point_accumulator #(.WIDTH(16), .COUNT_W(8), .GUARD(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .term_count   (term_count),
    .mul_result   (mul_result),
    .mul_overflow (mul_overflow),
    .mul_finish   (mul_finish),
    .acc_result   (acc_result),
    .acc_overflow (acc_overflow),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] tc);
    clear      = 1'b1;
    term_count = tc;
    cyc(1);
    clear = 1'b0;
  endtask

  // One product: finish low for a cycle, then a 0->1 edge sampled at the next clock.
  task automatic push(input logic [15:0] v, input logic ovf);
    mul_finish = 1'b0;
    cyc(1);
    mul_result   = v;
    mul_overflow = ovf;
    mul_finish   = 1'b1;
    cyc(1);
    mul_finish   = 1'b0;
    mul_overflow = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] res, input logic ovf,
                           input logic d, input logic b);
    check_val({tag, "_res"},  32'(acc_result),   32'(res));
    check_val({tag, "_ovf"},  32'(acc_overflow), 32'(ovf));
    check_val({tag, "_done"}, 32'(done),         32'(d));
    check_val({tag, "_busy"}, 32'(busy),         32'(b));
  endtask

  task automatic run_t1(input string tag);
    start(8'd3);
    check_val({tag, "_busy0"}, 32'(busy), 32'd1);
    push(16'h0100, 1'b0);
    check_val({tag, "_done1"}, 32'(done), 32'd0);
    push(16'h0200, 1'b0);
    check_val({tag, "_done2"}, 32'(done), 32'd0);
    push(16'hFF00, 1'b0);
    check_out(tag, 16'h0200, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    clear        = 1'b0;
    term_count   = 8'd0;
    mul_result   = 16'h0000;
    mul_overflow = 1'b0;
    mul_finish   = 1'b0;

    cyc(2);
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    cyc(1);

    // T1 basic three-term sum, then outputs hold in DONE
    run_t1("t1");
    cyc(3);
    check_out("t1_hold", 16'h0200, 1'b0, 1'b1, 1'b0);

    // T2 positive and negative saturation
    start(8'd2);
    check_out("t2_accum_hold", 16'h0200, 1'b0, 1'b0, 1'b1);
    push(16'h7000, 1'b0);
    push(16'h7000, 1'b0);
    check_out("t2_pos", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    start(8'd2);
    push(16'h9000, 1'b0);
    check_out("t2_mid", 16'h7FFF, 1'b1, 1'b0, 1'b1);
    push(16'h9000, 1'b0);
    check_out("t2_neg", 16'h8000, 1'b1, 1'b1, 1'b0);

    // T3 sticky multiplier overflow with an in-range sum
    start(8'd2);
    push(16'h0010, 1'b1);
    push(16'h0020, 1'b0);
    check_out("t3", 16'h0030, 1'b1, 1'b1, 1'b0);

    // T4 finish held high counts once
    start(8'd2);
    mul_result = 16'h0005;
    mul_finish = 1'b1;
    cyc(20);
    check_out("t4_held", 16'h0030, 1'b1, 1'b0, 1'b1);
    push(16'h0007, 1'b0);
    check_out("t4_sum", 16'h000C, 1'b0, 1'b1, 1'b0);

    // T4 edge in DONE ignored; finish already high at clear needs a fresh edge
    mul_result = 16'h0100;
    mul_finish = 1'b1;
    cyc(2);
    check_out("t4_done_edge", 16'h000C, 1'b0, 1'b1, 1'b0);
    start(8'd1);
    cyc(3);
    check_out("t4_hi_at_clear", 16'h000C, 1'b0, 1'b0, 1'b1);
    push(16'h0003, 1'b0);
    check_out("t4_fresh", 16'h0003, 1'b0, 1'b1, 1'b0);

    // T5 zero terms finish immediately
    start(8'd0);
    check_out("t5_zero", 16'h0000, 1'b0, 1'b1, 1'b0);

    // T5 clear coincident with an accepted edge discards that product
    clear        = 1'b1;
    term_count   = 8'd1;
    mul_result   = 16'h0040;
    mul_finish   = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);
    check_out("t5_coincide", 16'h0000, 1'b0, 1'b0, 1'b1);
    push(16'h0002, 1'b0);
    check_out("t5_after", 16'h0002, 1'b0, 1'b1, 1'b0);

    // T6 asynchronous reset mid-accumulation
    start(8'd3);
    push(16'h0100, 1'b0);
    check_out("t6_pre", 16'h0002, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_out("t6_async", 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    cyc(1);
    push(16'h1111, 1'b0);
    check_out("t6_idle_edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    run_t1("t6_fresh");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
